// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default oversampling ratio and
// the ceil(log2) helper used to size counters. Used by both RX and TX sides.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_t;

    // Number of bits needed to count 0..value-1 (minimum 1).
    function automatic int clogb2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line, plus a one-cycle
// delayed copy used to detect the high-to-low start edge. All flops reset
// to 1 so that leaving reset on an idle line never looks like an edge.
module uart_rx_sync (
    input  logic clk,
    input  logic i_rst,
    input  logic i_data,
    output logic o_rx_s,
    output logic o_rx_prev,
    output logic o_fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    // Metastability chain followed by the edge-detect delay stage.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], i_data};
            prev_reg <= sync_reg[1];
        end
    end

    assign o_rx_s    = sync_reg[1];
    assign o_rx_prev = prev_reg;
    assign o_fall    = prev_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: NB_DATA data bits (LSB first), N_STOP stop
// bits, OVERSAMPLE i_tick pulses per bit. Rejects false starts by checking
// the line again in the middle of the start bit, and reports stop-bit
// (framing) errors. Optional parity checking is built when the macro
// UART_RX_PARITY_EN is defined; otherwise o_parity_err is tied to 0.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int N_STOP     = 1,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_data,
    input  logic               i_parity_odd,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int TW = clogb2(OVERSAMPLE);
    localparam int BW = clogb2(NB_DATA);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(N_STOP - 1);

    logic rx_s;
    logic rx_prev;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .o_rx_s    (rx_s),
        .o_rx_prev (rx_prev),
        .o_fall    (rx_fall)
    );

    uart_state_t        state_reg;
    logic [TW-1:0]      tick_cnt_reg;
    logic [BW-1:0]      bit_cnt_reg;
    logic [NB_DATA-1:0] shift_reg;
    logic               ferr_flag_reg;
    logic [NB_DATA-1:0] data_reg;
    logic               rxdone_reg;
    logic               ferr_reg;
    logic               perr_reg;
    logic               perr_flag_reg;
    logic               unused_rx_prev;

    // The edge detector already folds rx_prev in; keep the level visible
    // here without leaving a dangling net.
    assign unused_rx_prev = rx_prev;

    // Frame FSM: counters advance only on i_tick; the cycle that leaves IDLE
    // clears the tick counter, so a coincident tick is not counted twice.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ferr_flag_reg <= 1'b0;
            perr_flag_reg <= 1'b0;
            data_reg      <= '0;
            rxdone_reg    <= 1'b0;
            ferr_reg      <= 1'b0;
            perr_reg      <= 1'b0;
        end else begin
            rxdone_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tick_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    if (rx_fall) begin
                        ferr_flag_reg <= 1'b0;
                        perr_flag_reg <= 1'b0;
                        state_reg     <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (tick_cnt_reg == TICK_MID) begin
                            tick_cnt_reg <= '0;
                            // Line back high at mid start bit: it was a glitch.
                            state_reg    <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (tick_cnt_reg == TICK_END) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rx_s, shift_reg[NB_DATA-1:1]};
                            if (bit_cnt_reg == BIT_LAST) begin
                                bit_cnt_reg <= '0;
`ifdef UART_RX_PARITY_EN
                                state_reg   <= ST_PARITY;
`else
                                state_reg   <= ST_STOP;
`endif
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (i_tick) begin
                        if (tick_cnt_reg == TICK_END) begin
                            tick_cnt_reg  <= '0;
                            perr_flag_reg <= ((^shift_reg) ^ rx_s) != i_parity_odd;
                            state_reg     <= ST_STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (i_tick) begin
                        if (tick_cnt_reg == TICK_END) begin
                            tick_cnt_reg  <= '0;
                            ferr_flag_reg <= ferr_flag_reg | ~rx_s;
                            if (bit_cnt_reg == STOP_LAST) begin
                                // Publish the frame; outputs are valid while in DONE.
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_DONE;
                                rxdone_reg  <= 1'b1;
                                data_reg    <= shift_reg;
                                ferr_reg    <= ferr_flag_reg | ~rx_s;
                                perr_reg    <= perr_flag_reg;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data      = data_reg;
    assign o_rxdone    = rxdone_reg;
    assign o_frame_err = ferr_reg;

`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_reg;
`else
    logic unused_parity;
    assign unused_parity = i_parity_odd ^ perr_reg ^ perr_flag_reg;
    assign o_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame. Two instances: default 8N1/16x on
// line rx_a and NB_DATA=7, N_STOP=2 on line rx_b. i_tick pulses every 4 clk,
// so one bit time is 64 clk. Frames carry a parity bit when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_CLK = BIT_CLK;
`else
    localparam int PAR_CLK = 0;
`endif

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_tick;
    logic       rx_a;
    logic       rx_b;
    logic       i_parity_odd;
    logic [7:0] data_a;
    logic       done_a, ferr_a, perr_a;
    logic [6:0] data_b;
    logic       done_b, ferr_b, perr_b;

    int tick_div = 0;
    int cyc = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    int done_cyc_a = 0;
    int start_cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        cyc      <= cyc + 1;
    end
    assign i_tick = (tick_div == 3);

    uart_rx_frame dut_a (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_data       (rx_a),
        .i_parity_odd (i_parity_odd),
        .o_data       (data_a),
        .o_rxdone     (done_a),
        .o_frame_err  (ferr_a),
        .o_parity_err (perr_a)
    );

    uart_rx_frame #(.NB_DATA(7), .N_STOP(2), .OVERSAMPLE(16)) dut_b (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_data       (rx_b),
        .i_parity_odd (i_parity_odd),
        .o_data       (data_b),
        .o_rxdone     (done_b),
        .o_frame_err  (ferr_b),
        .o_parity_err (perr_b)
    );

    // Count rxdone pulses away from the active edge.
    always @(negedge clk) begin
        if (done_a) begin
            cnt_a      <= cnt_a + 1;
            done_cyc_a <= cyc;
            $display("rx_a frame: data=0x%02h ferr=%0b perr=%0b at cyc %0d", data_a, ferr_a, perr_a, cyc);
        end
        if (done_b) begin
            cnt_b <= cnt_b + 1;
            $display("rx_b frame: data=0x%02h ferr=%0b perr=%0b at cyc %0d", data_b, ferr_b, perr_b, cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Start bit, data LSB first, optional parity, stop bits from stop_bits[s].
    // The line is left at the level of the last stop bit.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int nstop, input logic [1:0] stop_bits, input logic par_flip);
        logic par;
        par = 1'b0;
        for (int i = 0; i < nbits; i++) par = par ^ data[i];
        par = par ^ i_parity_odd ^ par_flip;
        start_cyc = cyc;
        drive(sel, 1'b0);
        hold(BIT_CLK);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            hold(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        drive(sel, par);
        hold(BIT_CLK);
`endif
        for (int s = 0; s < nstop; s++) begin
            drive(sel, stop_bits[s]);
            hold(BIT_CLK);
        end
    endtask

    task automatic wait_done(input int sel, input int exp_cnt);
        int n;
        n = 0;
        while ((((sel == 0) ? cnt_a : cnt_b) < exp_cnt) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        hold(2);
    endtask

    initial begin
        int lat;
        int base_a;
        i_rst        = 1'b1;
        rx_a         = 1'b1;
        rx_b         = 1'b1;
        i_parity_odd = 1'b0;
        hold(5);
        check("reset_data", {24'd0, data_a}, 32'h00);
        check("reset_done", {31'd0, done_a}, 32'h0);
        check("reset_ferr", {31'd0, ferr_a}, 32'h0);
        check("reset_perr", {31'd0, perr_a}, 32'h0);
        i_rst = 1'b0;
        hold(10);

        // 0xA5 8N1
        send_frame(0, 9'h0A5, 8, 1, 2'b01, 1'b0);
        wait_done(0, 1);
        check("a5_count", cnt_a, 1);
        check("a5_data", {24'd0, data_a}, 32'hA5);
        check("a5_ferr", {31'd0, ferr_a}, 32'h0);
        check("a5_perr", {31'd0, perr_a}, 32'h0);
        lat = done_cyc_a - start_cyc;
        $display("a5 latency %0d clk", lat);
        check("a5_latency_window", ((lat >= 600 + PAR_CLK) && (lat <= 620 + PAR_CLK)) ? 32'd1 : 32'd0, 32'd1);

        // 4-tick low glitch, then a clean 0x3C
        drive(0, 1'b0);
        hold(16);
        drive(0, 1'b1);
        hold(2 * BIT_CLK);
        check("glitch_no_frame", cnt_a, 1);
        send_frame(0, 9'h03C, 8, 1, 2'b01, 1'b0);
        wait_done(0, 2);
        check("3c_count", cnt_a, 2);
        check("3c_data", {24'd0, data_a}, 32'h3C);
        check("3c_ferr", {31'd0, ferr_a}, 32'h0);

        // 0x5A with stop bit low; line then stays low
        send_frame(0, 9'h05A, 8, 1, 2'b00, 1'b0);
        wait_done(0, 3);
        check("5a_count", cnt_a, 3);
        check("5a_data", {24'd0, data_a}, 32'h5A);
        check("5a_ferr", {31'd0, ferr_a}, 32'h1);
        hold(10 * BIT_CLK);
        check("low_line_no_retrigger", cnt_a, 3);
        check("5a_data_held", {24'd0, data_a}, 32'h5A);
        drive(0, 1'b1);
        hold(BIT_CLK);
        check("rising_no_frame", cnt_a, 3);

        // 7-bit, 2 stop: 0x55 then back-to-back 0x2A with second stop low
        send_frame(1, 9'h055, 7, 2, 2'b11, 1'b0);
        wait_done(1, 1);
        check("b55_count", cnt_b, 1);
        check("b55_data", {25'd0, data_b}, 32'h55);
        check("b55_ferr", {31'd0, ferr_b}, 32'h0);
        send_frame(1, 9'h02A, 7, 2, 2'b01, 1'b0);
        wait_done(1, 2);
        check("b2a_count", cnt_b, 2);
        check("b2a_data", {25'd0, data_b}, 32'h2A);
        check("b2a_ferr", {31'd0, ferr_b}, 32'h1);
        check("b2a_perr", {31'd0, perr_b}, 32'h0);
        drive(1, 1'b1);
        hold(BIT_CLK);

`ifdef UART_RX_PARITY_EN
        // Odd parity, 0x01: parity bit 0 is correct, parity bit 1 is wrong
        i_parity_odd = 1'b1;
        send_frame(0, 9'h001, 8, 1, 2'b01, 1'b0);
        wait_done(0, 4);
        check("par_ok_data", {24'd0, data_a}, 32'h01);
        check("par_ok_perr", {31'd0, perr_a}, 32'h0);
        send_frame(0, 9'h001, 8, 1, 2'b01, 1'b1);
        wait_done(0, 5);
        check("par_bad_perr", {31'd0, perr_a}, 32'h1);
        check("par_bad_ferr", {31'd0, ferr_a}, 32'h0);
        i_parity_odd = 1'b0;
        hold(BIT_CLK);
`else
        check("perr_tied_low", {31'd0, perr_a}, 32'h0);
`endif

        // Reset during the data bits of 0xFF
        base_a = cnt_a;
        drive(0, 1'b0);
        hold(BIT_CLK);
        drive(0, 1'b1);
        hold(3 * BIT_CLK);
        i_rst = 1'b1;
        hold(1);
        i_rst = 1'b0;
        check("rst_mid_data", {24'd0, data_a}, 32'h00);
        check("rst_mid_ferr", {31'd0, ferr_a}, 32'h0);
        check("rst_mid_done", {31'd0, done_a}, 32'h0);
        check("rst_mid_data_b", {25'd0, data_b}, 32'h00);
        hold(8 * BIT_CLK);
        check("rst_no_frame", cnt_a, base_a);
        send_frame(0, 9'h081, 8, 1, 2'b01, 1'b0);
        wait_done(0, base_a + 1);
        check("81_count", cnt_a, base_a + 1);
        check("81_data", {24'd0, data_a}, 32'h81);
        check("81_ferr", {31'd0, ferr_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
